// File: rtl/weight_pkg.sv
// Shared definitions for the weight medium and its loader: geometry
// constants and the loader's state encoding.
package weight_pkg;

    localparam int WEIGHT_ADDRS = 24;
    localparam int WEIGHT_WIDTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        WRITE,
        WAIT,
        DONE
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles a byte stream into one WIDTH-bit word, first byte in the LSB lane.
// The word is never cleared: every lane is overwritten once per word.
module byte_packer #(
    parameter int WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       data_byte,
    input  logic             fire,
    input  logic             clear,
    output logic [WIDTH-1:0] word,
    output logic             last
);

    localparam int BYTES = WIDTH / 8;
    localparam int KW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [KW-1:0]    lane_reg;
    logic [BYTES-1:0] lane_hit;
    logic [WIDTH-1:0] word_reg;

    assign last = (lane_reg == KW'(BYTES - 1));
    assign word = word_reg;

    genvar gi;
    generate
        for (gi = 0; gi < BYTES; gi++) begin : g_lane
            assign lane_hit[gi] = fire && (lane_reg == KW'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_reg <= '0;
        end else if (clear) begin
            lane_reg <= '0;
        end else if (fire) begin
            lane_reg <= last ? '0 : lane_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_reg <= '0;
        end else begin
            for (int i = 0; i < BYTES; i++) begin
                if (lane_hit[i]) begin
                    word_reg[8*i +: 8] <= data_byte;
                end
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Packs a host byte stream into weight words and writes them one at a time
// into weight_medium, waiting for its completion pulse after each write.
module weight_loader
    import weight_pkg::*;
#(
    parameter int ADDRS = WEIGHT_ADDRS,
    parameter int WIDTH = WEIGHT_WIDTH
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       start_in,
    input  logic [$clog2(ADDRS+1)-1:0] count_in,
    input  logic [7:0]                 byte_in,
    input  logic                       byte_valid_in,
    output logic                       byte_ready_out,
    output logic [$clog2(ADDRS)-1:0]   addr_out,
    output logic [WIDTH-1:0]           weight_out,
    output logic                       write_enable_out,
    input  logic                       finished_in,
    output logic                       busy_out,
    output logic                       done_out,
    output logic [$clog2(ADDRS+1)-1:0] words_written_out
);

    localparam int CW = $clog2(ADDRS + 1);
    localparam int AW = $clog2(ADDRS);

    loader_state_t state_reg, state_next;
    logic [CW-1:0] target_reg, target_next;
    logic [CW-1:0] words_reg, words_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic          fire, clear, last;

    // Decoded from state alone so the handshake has no combinational loop.
    assign fire = byte_valid_in && (state_reg == COLLECT);

    byte_packer #(.WIDTH(WIDTH)) u_packer (
        .clk       (clk_in),
        .rst_n     (rst_n_in),
        .data_byte (byte_in),
        .fire      (fire),
        .clear     (clear),
        .word      (weight_out),
        .last      (last)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            words_reg  <= '0;
            addr_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            words_reg  <= words_next;
            addr_reg   <= addr_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        target_next      = target_reg;
        words_next       = words_reg;
        addr_next        = addr_reg;
        clear            = 1'b0;
        byte_ready_out   = 1'b0;
        write_enable_out = 1'b0;
        done_out         = 1'b0;
        busy_out         = 1'b1;
        case (state_reg)
            IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    target_next = (count_in > CW'(ADDRS)) ? CW'(ADDRS) : count_in;
                    addr_next   = '0;
                    words_next  = '0;
                    clear       = 1'b1;
                    state_next  = (count_in == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                byte_ready_out = 1'b1;
                if (fire && last) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                write_enable_out = 1'b1;
                state_next       = WAIT;
            end
            WAIT: begin
                if (finished_in) begin
                    words_next = words_reg + 1'b1;
                    // target never exceeds ADDRS, so addr stops at ADDRS-1.
                    if (words_reg + 1'b1 == target_reg) begin
                        state_next = DONE;
                    end else begin
                        addr_next  = addr_reg + 1'b1;
                        state_next = COLLECT;
                    end
                end
            end
            DONE: begin
                done_out   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign addr_out          = addr_reg;
    assign words_written_out = words_reg;

endmodule

// File: tb/tb_weight_loader.sv
// Table-driven sessions with random bytes, gaps and medium latency, checked
// against a word-level model, plus hand-written asynchronous reset sequences.
module tb_weight_loader;

    localparam int ADDRS = 24;
    localparam int WIDTH = 256;
    localparam int BYTES = WIDTH / 8;
    localparam int CW    = $clog2(ADDRS + 1);
    localparam int AW    = $clog2(ADDRS);

    typedef struct {
        int count;
        int mode;        // 0 ramp, 1 0x88/0x77 per word, 2 random
        int gap_pct;
        int lat;
        int restart_at;  // bytes taken before a stray start, -1 for none
        bit fin_on_write;
        int exp_writes;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start_in = 1'b0;
    logic [CW-1:0]    count_in = '0;
    logic [7:0]       byte_in = '0;
    logic             byte_valid_in = 1'b0;
    logic             byte_ready_out;
    logic [AW-1:0]    addr_out;
    logic [WIDTH-1:0] weight_out;
    logic             write_enable_out;
    logic             finished_in = 1'b0;
    logic             busy_out;
    logic             done_out;
    logic [CW-1:0]    words_written_out;

    weight_loader #(.ADDRS(ADDRS), .WIDTH(WIDTH)) dut (
        .clk_in            (clk),
        .rst_n_in          (rst_n),
        .start_in          (start_in),
        .count_in          (count_in),
        .byte_in           (byte_in),
        .byte_valid_in     (byte_valid_in),
        .byte_ready_out    (byte_ready_out),
        .addr_out          (addr_out),
        .weight_out        (weight_out),
        .write_enable_out  (write_enable_out),
        .finished_in       (finished_in),
        .busy_out          (busy_out),
        .done_out          (done_out),
        .words_written_out (words_written_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fin_cyc  = 0;
    int fin_cnt  = 0;
    int done_cnt = 0;
    bit pending  = 1'b0;
    bit fin_on_write = 1'b0;
    logic [7:0]       src_q[$];
    logic [7:0]       got_q[$];
    logic [AW-1:0]    wr_addr_q[$];
    logic [WIDTH-1:0] wr_data_q[$];

    task automatic check(input string name, input logic [WIDTH-1:0] act,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock of the environment: observe outputs, model the medium, feed bytes.
    task automatic step(input bit st, input int cnt, input int gap, input int lat);
        @(negedge clk);
        cyc++;
        start_in = st;
        count_in = CW'(cnt);
        if (write_enable_out) begin
            wr_addr_q.push_back(addr_out);
            wr_data_q.push_back(weight_out);
            pending = 1'b1;
            fin_cnt = lat;
        end
        if (pending) check("ready_low_while_writing", byte_ready_out, 0);
        if (done_out) begin
            done_cnt++;
            check("done_timing", cyc, fin_cyc + 1);
        end
        finished_in = 1'b0;
        if (write_enable_out && fin_on_write) begin
            finished_in = 1'b1;
        end else if (pending && !write_enable_out) begin
            if (fin_cnt <= 0) begin
                finished_in = 1'b1;
                pending     = 1'b0;
                fin_cyc     = cyc;
            end else begin
                fin_cnt--;
            end
        end
        if (src_q.size() > 0 && $urandom_range(99) >= gap) begin
            byte_valid_in = 1'b1;
            byte_in       = src_q[0];
        end else begin
            byte_valid_in = 1'b0;
        end
        if (byte_valid_in && byte_ready_out) got_q.push_back(src_q.pop_front());
    endtask

    task automatic reset_env();
        src_q.delete();
        got_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        pending  = 1'b0;
        done_cnt = 0;
    endtask

    task automatic run_session(input vec_t v, input int id);
        int target;
        int budget;
        bit restarted;
        bit st;
        logic [7:0] bytes[$];
        logic [7:0] b;
        logic [WIDTH-1:0] exp_w;
        logic [WIDTH-1:0] ramp;
        reset_env();
        fin_on_write = v.fin_on_write;
        restarted = 1'b0;
        target = (v.count > ADDRS) ? ADDRS : v.count;
        for (int i = 0; i < BYTES * (target + 1); i++) begin
            if (v.mode == 0)      b = 8'(i);
            else if (v.mode == 1) b = ((i / BYTES) % 2 == 0) ? 8'h88 : 8'h77;
            else                  b = 8'($urandom);
            bytes.push_back(b);
            src_q.push_back(b);
        end
        step(1'b1, v.count, v.gap_pct, v.lat);
        fin_cyc = cyc;
        budget = 200 + target * (BYTES * 4 + v.lat + 20);
        while (done_cnt == 0 && budget > 0) begin
            st = !restarted && v.restart_at >= 0 && got_q.size() == v.restart_at;
            if (st) restarted = 1'b1;
            step(st, st ? ADDRS : v.count, v.gap_pct, v.lat);
            budget--;
        end
        for (int i = 0; i < 4; i++) step(1'b0, v.count, v.gap_pct, v.lat);
        byte_valid_in = 1'b0;
        check("done_count", done_cnt, 1);
        check("write_count", wr_addr_q.size(), v.exp_writes);
        for (int i = 0; i < wr_addr_q.size() && i < v.exp_writes; i++) begin
            exp_w = '0;
            for (int k = 0; k < BYTES; k++) exp_w[8*k +: 8] = bytes[BYTES*i + k];
            check("write_addr", wr_addr_q[i], i);
            check("write_data", wr_data_q[i], exp_w);
        end
        if (v.mode == 0 && wr_data_q.size() > 0) begin
            ramp = 256'h1F1E1D1C1B1A191817161514131211100F0E0D0C0B0A09080706050403020100;
            check("ramp_word", wr_data_q[0], ramp);
        end
        check("bytes_taken", got_q.size(), BYTES * v.exp_writes);
        check("words_written", words_written_out, v.exp_writes);
        check("final_addr", addr_out, (v.exp_writes > 0) ? v.exp_writes - 1 : 0);
        check("busy_after_done", busy_out, 0);
        $display("session %0d: count=%0d writes=%0d bytes_taken=%0d words_written=%0d",
                 id, v.count, wr_addr_q.size(), got_q.size(), words_written_out);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy_out, 0);
        check({tag, "_ready"}, byte_ready_out, 0);
        check({tag, "_we"}, write_enable_out, 0);
        check({tag, "_done"}, done_out, 0);
        check({tag, "_addr"}, addr_out, 0);
        check({tag, "_weight"}, weight_out, 0);
        check({tag, "_words"}, words_written_out, 0);
    endtask

    vec_t vecs[9];
    vec_t fresh;
    int   guard;

    initial begin
        vecs[0] = '{1,  0, 0,  2, -1, 1'b0, 1};
        vecs[1] = '{2,  1, 0,  1, -1, 1'b0, 2};
        vecs[2] = '{1,  0, 50, 2, -1, 1'b0, 1};
        vecs[3] = '{25, 2, 20, 0, -1, 1'b0, 24};
        vecs[4] = '{0,  2, 0,  1, -1, 1'b0, 0};
        vecs[5] = '{3,  2, 30, 3, 5,  1'b0, 3};
        vecs[6] = '{1,  2, 0,  4, -1, 1'b1, 1};
        vecs[7] = '{31, 2, 0,  0, -1, 1'b0, 24};
        vecs[8] = '{5,  1, 40, 6, -1, 1'b0, 5};
        fresh   = '{1,  0, 0,  2, -1, 1'b0, 1};

        #2 rst_n = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_session(vecs[i], i);

        // Reset after ten bytes of a word: outputs clear without a clock edge.
        reset_env();
        fin_on_write = 1'b0;
        for (int i = 0; i < BYTES; i++) src_q.push_back(8'(8'h40 + i));
        step(1'b1, 1, 0, 2);
        guard = 0;
        while (got_q.size() < 10 && guard < 100) begin
            step(1'b0, 1, 0, 2);
            guard++;
        end
        check("ten_bytes_taken", got_q.size(), 10);
        @(posedge clk);
        #1 byte_valid_in = 1'b0;
        check("weight_partial", weight_out[79:0], 80'h49484746454443424140);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_write_in_reset", write_enable_out, 0);
        end
        rst_n = 1'b1;
        run_session(fresh, 9);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
